dht_read_ctrl: RTL and testbench
================================

DHT_READ_CTRL -- requirements
Module: dht_read_ctrl

Interface
REQ-001 SHALL provide parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency used to derive all protocol timings.
REQ-002 SHALL provide parameter THRESH_US, default 40, high-pulse length above which a received bit is 1.
REQ-003 SHALL provide parameter TIMEOUT_US, default 200, maximum length of any single line phase after the start pulse.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle read request.
REQ-007 dht_in  input  1  sensor line level, asynchronous.
REQ-008 dht_oe  output  1  1 = drive sensor line low (open drain), 0 = release.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse at end of every read, good or failed.
REQ-011 error  output  1  last read failed; valid with done, held until next accepted start.
REQ-012 err_code  output  2  0 none, 1 no response, 2 bit timeout, 3 checksum mismatch.
REQ-013 data  output  40  last good frame: data[39:32] checksum, [31:24] low temp, [23:16] high temp, [15:8] low humidity, [7:0] high humidity.

Function
REQ-014 dht_in SHALL pass a two-flop synchronizer; all decisions use the synchronized level (2-cycle latency).
REQ-015 States SHALL be IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, FINISH.
REQ-016 IDLE: start=1 -> START_LOW, busy=1, error=0, err_code=0, cycle counter cleared.
REQ-017 START_LOW: dht_oe=1 for exactly 18 ms (CLK_FREQ_HZ*18/1000 cycles) -> WAIT_RESP with dht_oe=0.
REQ-018 WAIT_RESP: line low -> RESP_LOW; line still high after TIMEOUT_US -> FINISH with err_code=1.
REQ-019 RESP_LOW: line high -> RESP_HIGH; RESP_HIGH: line low -> BIT_LOW; timeout in either -> FINISH, err_code=1.
REQ-020 BIT_LOW: line high -> BIT_HIGH, counter cleared; BIT_HIGH: line low -> bit = (high count > THRESH_US cycles), bit index+1, -> BIT_LOW, or FINISH after bit 39.
REQ-021 Timeout in BIT_LOW or BIT_HIGH SHALL go to FINISH with err_code=2.
REQ-022 Byte k (k=0..4, in arrival order) SHALL fill shift-register bits [8k+7:8k], MSB first.
REQ-023 FINISH (one cycle): if no timeout, compute sum of bytes 0..3 modulo 256 (8-bit wrap) and compare with byte 4.
REQ-024 FINISH: done=1, busy=0, -> IDLE; data updated only if error=0, otherwise previous data retained.
REQ-025 start while busy SHALL be ignored; start in the same cycle as done SHALL be ignored.
REQ-026 dht_oe SHALL be 0 in every state except START_LOW.

Reset
REQ-027 reset SHALL force IDLE, dht_oe=0, busy=0, done=0, error=0, err_code=0, data=0, counters and bit index 0, including mid-read (line released next cycle, no done pulse).

Configuration
REQ-028 Macro DHT_CHECKSUM_EN defined: REQ-023 check active, mismatch gives error=1, err_code=3.
REQ-029 DHT_CHECKSUM_EN undefined: no comparison logic; any frame completing 40 bits is good and latched into data.

Structure
REQ-030 Package dht_pkg SHALL hold the state enum, err_code constants and cycle-count helper for microseconds/milliseconds.
REQ-031 Sub-module dht_phase_timer SHALL hold the cycle counter with clear, >THRESH and >TIMEOUT compare outputs.

Verification
REQ-032 Sensor model sends bytes 0x35,0x00,0x18,0x00,0x4D -> done, error=0, data=0x4D00180035.
REQ-033 Bytes 0x35,0x00,0x18,0x00,0x4E -> error=1, err_code=3, data unchanged; undefined DHT_CHECKSUM_EN -> error=0, data=0x4E00180035.
REQ-034 Sensor silent -> dht_oe low 18 ms, done at 18 ms + TIMEOUT_US + 2 cycles, err_code=1.
REQ-035 Line stuck high after 12 bits -> err_code=2 after TIMEOUT_US, busy=0.
REQ-036 Bytes 0xFF,0xFF,0xFF,0xFF,0xFC -> wrapped sum matches, error=0; bit highs of 26 us -> 0, 70 us -> 1.
REQ-037 reset asserted at bit 20 -> dht_oe=0, busy=0, no done; new start then reads a clean frame.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types, error codes and timing helpers for the DHT single-wire reader.
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_RESP,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_FINISH
    } dht_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_RESP  = 2'd1;
    localparam logic [1:0] ERR_BIT_TMO  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    localparam int unsigned FRAME_BITS  = 40;
    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned us);
        return 32'((64'(freq_hz) * 64'(us)) / 64'd1_000_000);
    endfunction

    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return 32'((64'(freq_hz) * 64'(ms)) / 64'd1_000);
    endfunction

    // Arrival index -> shift-register position: byte k lands in [8k+7:8k], MSB first.
    function automatic logic [5:0] bit_pos(input logic [5:0] idx);
        return {idx[5:3], ~idx[2:0]};
    endfunction

endpackage

// File: rtl/dht_phase_timer.sv
// Cycle counter for the current line phase, with pulse-length and timeout compares.
module dht_phase_timer #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned THRESH_CYC  = 2000,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             over_thresh_c,
    output logic             over_timeout_c
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // count lags the elapsed phase length by one, so >= here means elapsed > limit
    assign over_thresh_c  = (count >= CNT_W'(THRESH_CYC));
    assign over_timeout_c = (count >= CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/dht_read_ctrl.sv
// DHT11/22 style single-wire read controller: start pulse, response, 40 data bits.
// Define DHT_CHECKSUM_EN to verify the checksum byte before latching the frame.
module dht_read_ctrl
    import dht_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned THRESH_US   = 40,
    parameter int unsigned TIMEOUT_US  = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [39:0] data
);

    localparam int unsigned START_CYC   = ms_to_cycles(CLK_FREQ_HZ, 18);
    localparam int unsigned THRESH_CYC  = us_to_cycles(CLK_FREQ_HZ, THRESH_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int unsigned CNT_MAX_A   = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_MAX     = (CNT_MAX_A > THRESH_CYC) ? CNT_MAX_A : THRESH_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 2);

    dht_state_e        state;
    logic [1:0]        sync_q;
    logic              line;
    logic [CNT_W-1:0]  count;
    logic              over_thresh_c;
    logic              over_timeout_c;
    logic              clear_c;
    logic              start_end_c;
    logic              resp_seen_c;
    logic [5:0]        bit_idx;
    logic [39:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], dht_in};
        end
    end

    assign line        = sync_q[1];
    assign start_end_c = (count == CNT_W'(START_CYC - 1));
    // Just after release the synchronizer still shows our own low drive; ignore it.
    assign resp_seen_c = !line && (count >= CNT_W'(SYNC_STAGES));

    // Restart the phase timer on every state change; hold it cleared while idle.
    always_comb begin
        clear_c = 1'b1;
        case (state)
            ST_START_LOW: clear_c = start_end_c;
            ST_WAIT_RESP: clear_c = resp_seen_c || over_timeout_c;
            ST_RESP_LOW:  clear_c = line || over_timeout_c;
            ST_RESP_HIGH: clear_c = !line || over_timeout_c;
            ST_BIT_LOW:   clear_c = line || over_timeout_c;
            ST_BIT_HIGH:  clear_c = !line || over_timeout_c;
            default:      clear_c = 1'b1;
        endcase
    end

    dht_phase_timer #(
        .CNT_W       (CNT_W),
        .THRESH_CYC  (THRESH_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear_c),
        .count          (count),
        .over_thresh_c  (over_thresh_c),
        .over_timeout_c (over_timeout_c)
    );

`ifdef DHT_CHECKSUM_EN
    logic [7:0] sum_c;
    assign sum_c = shreg[7:0] + shreg[15:8] + shreg[23:16] + shreg[31:24];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            dht_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            data     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        state    <= ST_START_LOW;
                        dht_oe   <= 1'b1;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        bit_idx  <= '0;
                    end
                end
                ST_START_LOW: begin
                    if (start_end_c) begin
                        state  <= ST_WAIT_RESP;
                        dht_oe <= 1'b0;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_seen_c) begin
                        state <= ST_RESP_LOW;
                    end else if (over_timeout_c) begin
                        state    <= ST_FINISH;
                        error    <= 1'b1;
                        err_code <= ERR_NO_RESP;
                    end
                end
                ST_RESP_LOW: begin
                    if (line) begin
                        state <= ST_RESP_HIGH;
                    end else if (over_timeout_c) begin
                        state    <= ST_FINISH;
                        error    <= 1'b1;
                        err_code <= ERR_NO_RESP;
                    end
                end
                ST_RESP_HIGH: begin
                    if (!line) begin
                        state <= ST_BIT_LOW;
                    end else if (over_timeout_c) begin
                        state    <= ST_FINISH;
                        error    <= 1'b1;
                        err_code <= ERR_NO_RESP;
                    end
                end
                ST_BIT_LOW: begin
                    if (line) begin
                        state <= ST_BIT_HIGH;
                    end else if (over_timeout_c) begin
                        state    <= ST_FINISH;
                        error    <= 1'b1;
                        err_code <= ERR_BIT_TMO;
                    end
                end
                ST_BIT_HIGH: begin
                    if (!line) begin
                        shreg[bit_pos(bit_idx)] <= over_thresh_c;
                        bit_idx <= bit_idx + 6'd1;
                        state   <= (bit_idx == 6'(FRAME_BITS - 1)) ? ST_FINISH : ST_BIT_LOW;
                    end else if (over_timeout_c) begin
                        state    <= ST_FINISH;
                        error    <= 1'b1;
                        err_code <= ERR_BIT_TMO;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef DHT_CHECKSUM_EN
                    if (!error) begin
                        if (sum_c == shreg[39:32]) begin
                            data <= shreg;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                    end
`else
                    if (!error) begin
                        data <= shreg;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_read_ctrl.sv
// Directed + randomized bench for dht_read_ctrl with an open-drain sensor model.
// Honours DHT_CHECKSUM_EN the same way the design does.
module tb_dht_read_ctrl;

    localparam int unsigned CLK_HZ     = 250_000;
    localparam int unsigned THR_US     = 40;
    localparam int unsigned TMO_US     = 200;
    localparam int unsigned US_PER_CYC = 1_000_000 / CLK_HZ;
    localparam int unsigned START_LEN  = CLK_HZ * 18 / 1000;
    localparam int unsigned TMO_CYC    = TMO_US / US_PER_CYC;
    localparam int unsigned SHORT_H    = 26 / US_PER_CYC;
    localparam int unsigned LONG_H     = 70 / US_PER_CYC;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sens;
    logic        dht_in;
    logic        dht_oe;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [39:0] data;

    int          checks;
    int          errors;
    logic [39:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [39:0] frm;

    // Open-drain line: low whenever the controller drives, otherwise the sensor level.
    assign dht_in = dht_oe ? 1'b0 : sens;

    dht_read_ctrl #(
        .CLK_FREQ_HZ (CLK_HZ),
        .THRESH_US   (THR_US),
        .TIMEOUT_US  (TMO_US)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dht_in   (dht_in),
        .dht_oe   (dht_oe),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .data     (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic lvl, input int n);
        sens = lvl;
        tick(n);
    endtask

    task automatic begin_read(input string tag);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk({tag, " busy_on_start"}, 64'(busy), 64'(1));
        chk({tag, " oe_on_start"}, 64'(dht_oe), 64'(1));
    endtask

    task automatic check_start_pulse(input string tag);
        int n;
        n = 0;
        while (dht_oe === 1'b1 && n < int'(START_LEN) + 100) begin
            n++;
            tick(1);
        end
        chk({tag, " start_low_len"}, 64'(n), 64'(START_LEN));
    endtask

    task automatic send_resp();
        drive(1'b1, 6);
        drive(1'b0, 20);
        drive(1'b1, 20);
    endtask

    // Bits go out byte 0 first, each byte MSB first; high length encodes the value.
    task automatic send_bits(input int nbits, input bit rnd);
        for (int i = 0; i < nbits; i++) begin
            int   idx;
            int   lo;
            int   hi;
            logic b;
            idx = 8 * (i / 8) + 7 - (i % 8);
            b   = frm[idx];
            lo  = rnd ? int'($urandom_range(8, 20)) : 12;
            if (b) hi = rnd ? int'($urandom_range(12, 25)) : int'(LONG_H);
            else   hi = rnd ? int'($urandom_range(3, 9))   : int'(SHORT_H);
            drive(1'b0, lo);
            drive(1'b1, hi);
        end
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic check_result(input string tag);
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " err_code"}, 64'(err_code), 64'(exp_code));
        chk({tag, " data"}, 64'(data), 64'(exp_data));
        chk({tag, " busy_off"}, 64'(busy), 64'(0));
        chk({tag, " oe_off"}, 64'(dht_oe), 64'(0));
        tick(1);
        chk({tag, " done_one_cycle"}, 64'(done), 64'(0));
    endtask

    // Reference outcome of a fully received frame.
    task automatic expect_frame(input logic [39:0] f);
        logic [7:0] s;
        s = f[7:0] + f[15:8] + f[23:16] + f[31:24];
        exp_err = 1'b0;
`ifdef DHT_CHECKSUM_EN
        if (s != f[39:32]) exp_err = 1'b1;
`endif
        if (s == f[39:32]) exp_err = exp_err;
        exp_code = exp_err ? 2'd3 : 2'd0;
        if (!exp_err) exp_data = f;
    endtask

    task automatic full_read(input string tag, input logic [39:0] f, input bit rnd);
        int k;
        frm = f;
        begin_read(tag);
        check_start_pulse(tag);
        send_resp();
        send_bits(40, rnd);
        sens = 1'b0;
        wait_done(tag, k);
        expect_frame(f);
        check_result(tag);
        sens = 1'b1;
        tick(4);
    endtask

    initial begin
        int          k;
        int          seen;
        logic [39:0] f;
        logic [7:0]  s;

        checks   = 0;
        errors   = 0;
        exp_data = '0;
        exp_err  = 1'b0;
        exp_code = 2'd0;
        frm      = '0;
        reset    = 1'b1;
        start    = 1'b0;
        sens     = 1'b1;
        tick(3);
        chk("reset dht_oe", 64'(dht_oe), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset error", 64'(error), 64'(0));
        chk("reset err_code", 64'(err_code), 64'(0));
        chk("reset data", 64'(data), 64'(0));
        reset = 1'b0;
        tick(2);

        full_read("good", 40'h4D_00_18_00_35, 1'b0);
        full_read("badsum", 40'h4E_00_18_00_35, 1'b0);

        // Silent sensor: no response after release.
        begin_read("silent");
        check_start_pulse("silent");
        wait_done("silent", k);
        chk("silent done_latency", 64'(k), 64'(TMO_CYC + 2));
        exp_err  = 1'b1;
        exp_code = 2'd1;
        check_result("silent");

        // Line stuck high in the high phase after 12 bits.
        frm = 40'hA5_5A_C3_3C_96;
        begin_read("stuck");
        check_start_pulse("stuck");
        send_resp();
        send_bits(12, 1'b0);
        drive(1'b0, 12);
        sens = 1'b1;
        wait_done("stuck", k);
        // 2 synchronizer flops + entry edge + (TIMEOUT+1) cycles over limit + FINISH
        chk("stuck done_latency", 64'(k), 64'(TMO_CYC + 5));
        exp_err  = 1'b1;
        exp_code = 2'd2;
        check_result("stuck");
        tick(4);

        // Wrap-around checksum; extra start while busy and a start alongside done.
        f   = 40'hFC_FF_FF_FF_FF;
        frm = f;
        begin_read("wrap");
        check_start_pulse("wrap");
        drive(1'b1, 6);
        start = 1'b1;
        drive(1'b0, 1);
        start = 1'b0;
        drive(1'b0, 19);
        chk("wrap busy_held", 64'(busy), 64'(1));
        drive(1'b1, 20);
        send_bits(40, 1'b0);
        sens = 1'b0;
        wait_done("wrap", k);
        expect_frame(f);
        start = 1'b1;
        check_result("wrap");
        start = 1'b0;
        sens  = 1'b1;
        tick(2);
        chk("start_with_done busy", 64'(busy), 64'(0));
        chk("start_with_done oe", 64'(dht_oe), 64'(0));
        tick(2);

        // Reset in the middle of the frame.
        frm = 40'h12_34_56_78_9A;
        begin_read("midreset");
        check_start_pulse("midreset");
        send_resp();
        send_bits(20, 1'b0);
        sens = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("midreset oe", 64'(dht_oe), 64'(0));
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset done", 64'(done), 64'(0));
        chk("midreset data", 64'(data), 64'(0));
        exp_data = '0;
        exp_err  = 1'b0;
        exp_code = 2'd0;
        reset = 1'b0;
        sens  = 1'b1;
        seen  = 0;
        repeat (200) begin
            tick(1);
            if (done === 1'b1) seen = 1;
        end
        chk("midreset no_done", 64'(seen), 64'(0));
        full_read("after_reset", 40'h4D_00_18_00_35, 1'b0);

        // Random frames and pulse lengths; the second one carries a random checksum.
        for (int r = 0; r < 3; r++) begin
            f[31:0] = $urandom;
            s = f[7:0] + f[15:8] + f[23:16] + f[31:24];
            f[39:32] = (r == 1) ? 8'($urandom) : s;
            full_read($sformatf("rand%0d", r), f, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
